// File: rtl/tog_pulse_rx.sv
// Receive end of a toggle-encoded event link: synchronise, detect level changes,
// and queue the resulting events behind a valid/ready pop with overrun tracking.
module tog_pulse_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PEND_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tog_in,
  input  logic              en,
  input  logic              clr_overrun,
  input  logic              evt_ready,
  output logic              evt_pulse,
  output logic              evt_valid,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  evt_total,
  output logic              overrun,
  output logic              tog_level
);

  localparam int unsigned       ARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0]  ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic {
    ARM,
    RUN
  } state_t;

  state_t                 state;
  logic [ARM_W-1:0]       arm_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  logic push;
  logic pop;
  logic full;
  logic ovr_set;

  assign tog_level = sync_q[SYNC_STAGES-1];
  assign evt_valid = (pend_cnt != '0);

  // Queue controls: the registered pulse is the push.
  assign push    = evt_pulse;
  assign pop     = evt_valid & evt_ready;
  assign full    = (pend_cnt == PEND_MAX);
  assign ovr_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARM;
      arm_cnt   <= '0;
      sync_q    <= '0;
      prev      <= 1'b0;
      evt_pulse <= 1'b0;
      pend_cnt  <= '0;
      evt_total <= '0;
      overrun   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
      prev   <= tog_level;

      // ARM lets prev settle onto the synchronised level before detecting edges.
      case (state)
        ARM: begin
          evt_pulse <= 1'b0;
          if (arm_cnt == ARM_LAST) begin
            state <= RUN;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end
        RUN: begin
          evt_pulse <= en & (tog_level ^ prev);
        end
        default: begin
          state     <= ARM;
          evt_pulse <= 1'b0;
        end
      endcase

      case ({push, pop})
        2'b10: if (!full) pend_cnt <= pend_cnt + PEND_W'(1);
        2'b01: pend_cnt <= pend_cnt - PEND_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase

      if (push) begin
        evt_total <= evt_total + CNT_W'(1);
      end

      // A set in the same cycle as a clear request wins.
      overrun <= ovr_set | (overrun & ~clr_overrun);
    end
  end

endmodule

// File: tb/tb_tog_pulse_rx.sv
// Bench for tog_pulse_rx: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an edge-history event model.
module tb_tog_pulse_rx;

  localparam int S    = 2;
  localparam int CW   = 8;
  localparam int PW   = 3;
  localparam int PMAX = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tog_in = 1'b0;
  logic          en = 1'b0;
  logic          clr_overrun = 1'b0;
  logic          evt_ready = 1'b0;
  logic          evt_pulse;
  logic          evt_valid;
  logic [PW-1:0] pend_cnt;
  logic [CW-1:0] evt_total;
  logic          overrun;
  logic          tog_level;

  always #5 clk = ~clk;

  tog_pulse_rx #(.SYNC_STAGES(S), .CNT_W(CW), .PEND_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .tog_in      (tog_in),
    .en          (en),
    .clr_overrun (clr_overrun),
    .evt_ready   (evt_ready),
    .evt_pulse   (evt_pulse),
    .evt_valid   (evt_valid),
    .pend_cnt    (pend_cnt),
    .evt_total   (evt_total),
    .overrun     (overrun),
    .tog_level   (tog_level)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: events are edges of the sampled tog_in history, seen S+1 edges later.
  int  e = 0;
  int  rst_e = 0;
  bit  tin [64];
  bit  model_ok = 0;
  bit  m_pulse = 0;
  int  m_pend = 0;
  int  m_total = 0;
  bit  m_ovr = 0;
  bit  m_push, m_pop, m_full;

  always @(posedge clk) begin
    e++;
    tin[e % 64] = tog_in;
    if (reset) begin
      m_pulse  = 0;
      m_pend   = 0;
      m_total  = 0;
      m_ovr    = 0;
      rst_e    = e;
      model_ok = 1;
    end else if (model_ok) begin
      m_push = m_pulse;
      m_pop  = evt_ready && (m_pend > 0);
      m_full = (m_pend == PMAX);
      if (m_push) m_total = (m_total + 1) % 256;
      if (m_push && m_full && !m_pop) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      if (m_push && !m_pop && !m_full) m_pend++;
      else if (m_pop && !m_push) m_pend--;
      m_pulse = (e - rst_e >= S + 2) && en && (tin[(e - S) % 64] != tin[(e - S - 1) % 64]);
    end
  end

  function automatic bit m_level();
    return (e - rst_e >= S) ? tin[(e - S + 1) % 64] : 1'b0;
  endfunction

  always @(negedge clk) begin
    if (evt_pulse === 1'b1) pulses++;
    if (model_ok) begin
      chk("m_pulse", 32'(evt_pulse), 32'(m_pulse));
      chk("m_valid", 32'(evt_valid), 32'(m_pend != 0));
      chk("m_pend", 32'(pend_cnt), 32'(m_pend));
      chk("m_total", 32'(evt_total), 32'(m_total));
      chk("m_overrun", 32'(overrun), 32'(m_ovr));
      chk("m_level", 32'(tog_level), 32'(m_level()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(S + 4);
  endtask

  task automatic toggle_hold(input int n);
    tog_in = ~tog_in;
    tick(n);
  endtask

  int  hold;
  int  rdy_pct;
  bit  found;

  initial begin
    // Reset release with tog_in high must not produce an event.
    reset  = 1'b1;
    tog_in = 1'b1;
    en     = 1'b1;
    tick(2);
    reset  = 1'b0;
    pulses = 0;
    tick(20);
    chk("t1_pulses", 32'(pulses), 0);
    chk("t1_pend", 32'(pend_cnt), 0);
    chk("t1_total", 32'(evt_total), 0);

    // Two edges, exact pulse latency of S+1 edges.
    tog_in = 1'b0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      tog_in = ~tog_in;
      tick(2);
      chk("t2_early", 32'(evt_pulse), 0);
      tick(1);
      chk("t2_pulse", 32'(evt_pulse), 1);
      tick(7);
    end
    chk("t2_pend", 32'(pend_cnt), 2);
    chk("t2_total", 32'(evt_total), 2);

    // Saturation and overrun.
    do_reset();
    for (int i = 0; i < 9; i++) toggle_hold(10);
    chk("t3_pend", 32'(pend_cnt), 7);
    chk("t3_overrun", 32'(overrun), 1);
    chk("t3_total", 32'(evt_total), 9);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    chk("t3_cleared", 32'(overrun), 0);

    // Push at full coinciding with a pop.
    tog_in = ~tog_in;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (evt_pulse === 1'b1) found = 1;
    end
    chk("t4_pulse_seen", 32'(found), 1);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    tick(3);
    chk("t4_pend", 32'(pend_cnt), 7);
    chk("t4_overrun", 32'(overrun), 0);
    chk("t4_total", 32'(evt_total), 10);

    // Events dropped while disabled; re-enable creates nothing by itself.
    do_reset();
    pulses = 0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) toggle_hold(10);
    en = 1'b1;
    tick(10);
    chk("t5_pulses", 32'(pulses), 0);
    chk("t5_pend", 32'(pend_cnt), 0);
    toggle_hold(10);
    chk("t5_pulses_after", 32'(pulses), 1);
    chk("t5_pend_after", 32'(pend_cnt), 1);

    // Mid-operation reset with pend_cnt=5, evt_total=200.
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 195; i++) toggle_hold(3);
    tick(6);
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) toggle_hold(3);
    tick(4);
    chk("t6_pend", 32'(pend_cnt), 5);
    chk("t6_total", 32'(evt_total), 200);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_rst_pulse", 32'(evt_pulse), 0);
    chk("t6_rst_valid", 32'(evt_valid), 0);
    chk("t6_rst_pend", 32'(pend_cnt), 0);
    chk("t6_rst_total", 32'(evt_total), 0);
    chk("t6_rst_overrun", 32'(overrun), 0);
    chk("t6_rst_level", 32'(tog_level), 0);
    tog_in = ~tog_in;
    pulses = 0;
    tick(20);
    chk("t6_arm_pulses", 32'(pulses), 0);
    chk("t6_arm_pend", 32'(pend_cnt), 0);
    chk("t6_arm_level", 32'(tog_level), 32'(tog_in));

    // Randomized traffic against the model.
    do_reset();
    hold = 2;
    rdy_pct = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rdy_pct = (c % 1500 == 0) ? 10 : ((c % 1000 == 0) ? 80 : 40);
      if (hold == 0) begin
        tog_in = ~tog_in;
        hold = $urandom_range(2, 6);
      end
      hold--;
      en          = ($urandom % 8) != 0;
      evt_ready   = ($urandom % 100) < rdy_pct;
      clr_overrun = ($urandom % 16) == 0;
      reset       = ($urandom % 700) == 0;
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
